gpio_ctrl_param: RTL and testbench
==================================

// Module: gpio_ctrl_param
// PURPOSE
//  Parametrised GPIO peripheral on the 12-bit-address memory-mapped peripheral bus.
//  Provides a synchronised, digitally filtered input port with a programmable sample prescaler.
//  Provides an output port with atomic set/clear/toggle aliases.
//  Provides per-pin rise/fall edge capture with a single level interrupt to the core.
// PARAMETERS
//  NUM_IN   16  input pin count (1..32)
//  NUM_OUT   8  output pin count (1..32)
//  DIV_W    16  prescaler register width (1..32)
//  FILT_W    4  filter-count register width; max filter length 2^FILT_W-1
// PORTS
//  clk           in   1        global clock
//  rst_n         in   1        async active-low reset
//  sel           in   1        block select
//  addr          in   12       byte address; addr[11:2] decoded, addr[1:0] ignored
//  we            in   3        [2]=write strobe, [1:0]=size 00 byte/01 half/10 word
//  wdata         in   32       write data
//  rdata         out  32       read data (combinational)
//  gpio_pin_in   in   NUM_IN   asynchronous input pins
//  gpio_pin_out  out  NUM_OUT  output pins
//  irq           out  1        interrupt, high while any IRQ_STAT bit is set
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
//   rst_n=0 clears all registers, sync/filter state, counters and the prescaler.
//   Outputs reset to gpio_pin_out=0, irq=0; rdata=0 while sel=0.
//  Bus write:
//   - Occurs at posedge clk when sel & we[2].
//   - Byte size writes bits[7:0], half writes [15:0], word writes [31:0] of the addressed register; other bits keep their value.
//   - Register bits beyond the implemented width are ignored on write and read 0.
//  Bus read: rdata = sel ? reg[addr] : 0, combinational; write-only and unmapped addresses read 0; unmapped writes are ignored.
//  Register map:
//   000 FILT     RW  FILT_W   consecutive differing samples required to change IN; 0 = bypass
//   004 REFDIV   RW  DIV_W    sample tick every REFDIV+1 clk; a write restarts the prescaler at 0
//   010 IN       RO  NUM_IN   filtered input value
//   020 OUT      RW  NUM_OUT  output value, drives gpio_pin_out directly
//   024 OUT_SET  WO           OUT |= wdata
//   028 OUT_CLR  WO           OUT &= ~wdata
//   02C OUT_TGL  WO           OUT ^= wdata
//   030 RISE_EN  RW  NUM_IN   enable rising-edge capture
//   034 FALL_EN  RW  NUM_IN   enable falling-edge capture
//   03C IRQ_STAT R/W1C NUM_IN sticky edge flags; writing 1 clears the bit
//  Input path:
//   - 2-FF synchroniser per pin, then filter stage.
//   - Prescaler counts 0..REFDIV; tick=1 for one clk when it wraps to 0. REFDIV=0 gives tick every clk.
//  Filter, FILT=0: IN <= sync every clk, ungated by tick. Pin-to-IN latency is 3 clk.
//  Filter, FILT=N>0, per bit, on tick only:
//   - sync==IN: counter <= 0.
//   - otherwise counter+1; on reaching N, IN <= sync and counter <= 0.
//   - A glitch shorter than N ticks never reaches IN.
//   - Writing FILT clears all filter counters.
//  Edges:
//   - rise = IN 0->1, fall = IN 1->0, detected on the IN register.
//   - IRQ_STAT[i] is set the clk after the IN change if the corresponding EN bit is set.
//   - A set and a W1C on the same bit in the same clk: the set wins.
//   - Clearing EN does not clear existing flags.
//   - irq = |IRQ_STAT, registered path; asserts 1 clk after the flag sets.
//  Output path:
//   - OUT updates at the write clk edge; gpio_pin_out follows with 0 additional latency.
//   - A SET/CLR/TGL byte/half write affects only the written byte lanes.
//  Reset mid-operation: all state returns to reset values immediately; no pending edge survives.
// TESTING
//  1. Reset values: read 000/004/010/020/030/034/03C -> all 0; sel=0 -> rdata=0; irq=0.
//  2. Size masking: word write 0xAAAAAAAA to 020, then half write 0x00005555 -> OUT=0x55 (NUM_OUT=8); byte write to 004 of 0x12 over 0x3456 -> 0x3412.
//  3. Atomic ops: OUT=0x0F; SET 0xF0 -> 0xFF; CLR 0x81 -> 0x7E; TGL 0xFF -> 0x81; reads of 024/028/02C -> 0.
//  4. Bypass input: FILT=0, REFDIV=0; pins 0xFFFF -> IN=0xFFFF within 3 clk; then 0x5555 -> 0x5555; then 0xAAAA -> 0xAAAA.
//  5. Filter: FILT=3, REFDIV=4; a 2-tick (10 clk) pulse on pin0 -> IN stays 0; a 3-tick pulse -> IN[0]=1 on the 3rd tick.
//  6. IRQ: RISE_EN=1, FALL_EN=2; pin0 rise -> STAT=1, irq=1; pin1 fall -> STAT=3; W1C 1 coincident with a new pin0 rise -> bit0 stays 1; W1C 3 -> irq=0; rst_n low mid-sequence -> all 0.

Source files
------------

// File: rtl/gpio_ctrl_param.sv
// Parametrised GPIO peripheral with a synchronised and filtered input port and atomic output aliases.
// It also provides rise/fall edge capture into sticky W1C flags and a single registered interrupt.
module gpio_ctrl_param #(
   parameter int NUM_IN  = 16,
   parameter int NUM_OUT = 8,
   parameter int DIV_W   = 16,
   parameter int FILT_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sel,
   input  logic [11:0]        addr,
   input  logic [2:0]         we,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   input  logic [NUM_IN-1:0]  gpio_pin_in,
   output logic [NUM_OUT-1:0] gpio_pin_out,
   output logic               irq
);

   localparam logic [9:0] A_FILT   = 10'h000;
   localparam logic [9:0] A_REFDIV = 10'h001;
   localparam logic [9:0] A_IN     = 10'h004;
   localparam logic [9:0] A_OUT    = 10'h008;
   localparam logic [9:0] A_SET    = 10'h009;
   localparam logic [9:0] A_CLR    = 10'h00A;
   localparam logic [9:0] A_TGL    = 10'h00B;
   localparam logic [9:0] A_RISE   = 10'h00C;
   localparam logic [9:0] A_FALL   = 10'h00D;
   localparam logic [9:0] A_STAT   = 10'h00F;

   logic [FILT_W-1:0]  filt_q, filt_nxt;
   logic [DIV_W-1:0]   refdiv_q, refdiv_nxt, div_cnt;
   logic [NUM_OUT-1:0] out_q, out_nxt;
   logic [NUM_IN-1:0]  rise_en, rise_nxt, fall_en, fall_nxt;
   logic [NUM_IN-1:0]  stat_q, w1c, edge_set;
   logic [NUM_IN-1:0]  sync1, sync2, in_q, in_d;
   logic [FILT_W-1:0]  fcnt [NUM_IN];
   logic [9:0]         idx;
   logic [31:0]        lane_mask, lanes;
   logic               wr, filt_wr, refdiv_wr, tick;
   logic               unused_addr;

   assign idx         = addr[11:2];
   assign unused_addr = &{1'b0, addr[1:0]};
   assign wr          = sel & we[2];
   assign filt_wr     = wr && (idx == A_FILT);
   assign refdiv_wr   = wr && (idx == A_REFDIV);
   assign lanes       = wdata & lane_mask;
   assign tick        = (div_cnt == refdiv_q);
   assign edge_set    = (in_q & ~in_d & rise_en) | (~in_q & in_d & fall_en);
   assign gpio_pin_out = out_q;

   always_comb begin
      case (we[1:0])
         2'b00:   lane_mask = 32'h0000_00FF;
         2'b01:   lane_mask = 32'h0000_FFFF;
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
   end

   // Register write decode; only the addressed byte lanes are merged into the old value
   always_comb begin
      filt_nxt   = filt_q;
      refdiv_nxt = refdiv_q;
      out_nxt    = out_q;
      rise_nxt   = rise_en;
      fall_nxt   = fall_en;
      w1c        = '0;
      if (wr) begin
         case (idx)
            A_FILT:   filt_nxt   = FILT_W'((32'(filt_q) & ~lane_mask) | lanes);
            A_REFDIV: refdiv_nxt = DIV_W'((32'(refdiv_q) & ~lane_mask) | lanes);
            A_OUT:    out_nxt    = NUM_OUT'((32'(out_q) & ~lane_mask) | lanes);
            A_SET:    out_nxt    = out_q | NUM_OUT'(lanes);
            A_CLR:    out_nxt    = out_q & ~NUM_OUT'(lanes);
            A_TGL:    out_nxt    = out_q ^ NUM_OUT'(lanes);
            A_RISE:   rise_nxt   = NUM_IN'((32'(rise_en) & ~lane_mask) | lanes);
            A_FALL:   fall_nxt   = NUM_IN'((32'(fall_en) & ~lane_mask) | lanes);
            A_STAT:   w1c        = NUM_IN'(lanes);
            default:  ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (idx)
            A_FILT:   rdata = 32'(filt_q);
            A_REFDIV: rdata = 32'(refdiv_q);
            A_IN:     rdata = 32'(in_q);
            A_OUT:    rdata = 32'(out_q);
            A_RISE:   rdata = 32'(rise_en);
            A_FALL:   rdata = 32'(fall_en);
            A_STAT:   rdata = 32'(stat_q);
            default:  rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q   <= '0;
         refdiv_q <= '0;
         out_q    <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
         stat_q   <= '0;
         irq      <= 1'b0;
         div_cnt  <= '0;
      end else begin
         filt_q   <= filt_nxt;
         refdiv_q <= refdiv_nxt;
         out_q    <= out_nxt;
         rise_en  <= rise_nxt;
         fall_en  <= fall_nxt;
         // A new edge wins over a coincident W1C of the same bit
         stat_q   <= (stat_q & ~w1c) | edge_set;
         irq      <= |stat_q;
         if (refdiv_wr || tick) div_cnt <= '0;
         else                   div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Synchroniser, per-bit glitch filter and the edge-detect history of IN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         in_q  <= '0;
         in_d  <= '0;
         for (int i = 0; i < NUM_IN; i++) fcnt[i] <= '0;
      end else begin
         sync1 <= gpio_pin_in;
         sync2 <= sync1;
         in_d  <= in_q;
         for (int i = 0; i < NUM_IN; i++) begin
            if (filt_q == '0) begin
               in_q[i] <= sync2[i];
               fcnt[i] <= '0;
            end else if (tick) begin
               if (sync2[i] == in_q[i]) begin
                  fcnt[i] <= '0;
               end else if (fcnt[i] + FILT_W'(1) == filt_q) begin
                  in_q[i] <= sync2[i];
                  fcnt[i] <= '0;
               end else begin
                  fcnt[i] <= fcnt[i] + FILT_W'(1);
               end
            end
            if (filt_wr) fcnt[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_gpio_ctrl_param.sv
// Directed testbench for gpio_ctrl_param: a register-access vector table plus hand-written
// sequences for input latency, filtering, edge capture and mid-operation reset.
module tb_gpio_ctrl_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic [11:0] addr;
   logic [2:0]  we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] pins;
   logic [7:0]  pin_out;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        is_write;
      logic [11:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[$];

   gpio_ctrl_param #(.NUM_IN(16), .NUM_OUT(8), .DIV_W(16), .FILT_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sel          (sel),
      .addr         (addr),
      .we           (we),
      .wdata        (wdata),
      .rdata        (rdata),
      .gpio_pin_in  (pins),
      .gpio_pin_out (pin_out),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic addVec(input logic w, input logic [11:0] a, input logic [1:0] s, input logic [31:0] d);
      vec_t v;
      v.is_write = w;
      v.addr     = a;
      v.size     = s;
      v.data     = d;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge
   task automatic applyStimulus(input logic [11:0] a, input logic [1:0] s, input logic [31:0] d);
      sel   = 1'b1;
      addr  = a;
      we    = {1'b1, s};
      wdata = d;
      @(negedge clk);
      sel   = 1'b0;
      we    = 3'b000;
      wdata = '0;
   endtask

   task automatic readNow(input logic [11:0] a, output logic [31:0] d);
      sel  = 1'b1;
      we   = 3'b000;
      addr = a;
      #1;
      d = rdata;
   endtask

   initial begin
      logic [31:0] d;
      logic        seen;
      int          rose_at;

      rst_n = 1'b0;
      sel   = 1'b0;
      addr  = 12'h020;
      we    = 3'b000;
      wdata = '0;
      pins  = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_irq", 32'(irq), 32'h0);
      checkOutput("reset_pin_out", 32'(pin_out), 32'h0);
      checkOutput("reset_sel0_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      addVec(0, 12'h000, 2, 32'h0);
      addVec(0, 12'h004, 2, 32'h0);
      addVec(0, 12'h010, 2, 32'h0);
      addVec(0, 12'h020, 2, 32'h0);
      addVec(0, 12'h030, 2, 32'h0);
      addVec(0, 12'h034, 2, 32'h0);
      addVec(0, 12'h03C, 2, 32'h0);
      addVec(1, 12'h020, 2, 32'hAAAA_AAAA);
      addVec(0, 12'h020, 2, 32'h0000_00AA);
      addVec(1, 12'h020, 1, 32'h0000_5555);
      addVec(0, 12'h020, 2, 32'h0000_0055);
      addVec(1, 12'h004, 2, 32'h0000_3456);
      addVec(1, 12'h004, 0, 32'h0000_0012);
      addVec(0, 12'h004, 2, 32'h0000_3412);
      addVec(1, 12'h004, 2, 32'hFFFF_FFFF);
      addVec(0, 12'h004, 2, 32'h0000_FFFF);
      addVec(1, 12'h004, 2, 32'h0);
      addVec(1, 12'h000, 2, 32'hFFFF_FFFF);
      addVec(0, 12'h000, 2, 32'h0000_000F);
      addVec(1, 12'h000, 2, 32'h0);
      addVec(1, 12'h020, 2, 32'h0000_000F);
      addVec(1, 12'h024, 2, 32'h0000_00F0);
      addVec(0, 12'h020, 2, 32'h0000_00FF);
      addVec(1, 12'h028, 2, 32'h0000_0081);
      addVec(0, 12'h020, 2, 32'h0000_007E);
      addVec(1, 12'h02C, 2, 32'h0000_00FF);
      addVec(0, 12'h020, 2, 32'h0000_0081);
      addVec(0, 12'h024, 2, 32'h0);
      addVec(0, 12'h028, 2, 32'h0);
      addVec(0, 12'h02C, 2, 32'h0);
      addVec(1, 12'h024, 0, 32'h0000_FF00);
      addVec(0, 12'h020, 2, 32'h0000_0081);
      addVec(0, 12'h022, 2, 32'h0000_0081);
      addVec(1, 12'h040, 2, 32'h1234_5678);
      addVec(0, 12'h040, 2, 32'h0);
      addVec(1, 12'h030, 2, 32'hFFFF_FFFF);
      addVec(0, 12'h030, 2, 32'h0000_FFFF);
      addVec(1, 12'h030, 2, 32'h0);

      @(negedge clk);
      foreach (vecs[i]) begin
         if (vecs[i].is_write) begin
            applyStimulus(vecs[i].addr, vecs[i].size, vecs[i].data);
         end else begin
            @(negedge clk);
            readNow(vecs[i].addr, d);
            checkOutput($sformatf("vec%0d_read_%03h", i, vecs[i].addr), d, vecs[i].data);
            if (vecs[i].addr == 12'h020)
               checkOutput($sformatf("vec%0d_pin_out", i), 32'(pin_out), vecs[i].data);
         end
      end

      @(negedge clk);
      sel  = 1'b0;
      addr = 12'h020;
      #1;
      checkOutput("sel0_rdata", rdata, 32'h0);

      // Bypass path: new pin value visible in IN after exactly three clocks
      pins = 16'hFFFF;
      repeat (2) @(negedge clk);
      readNow(12'h010, d);
      checkOutput("bypass_before_3clk", d, 32'h0);
      @(negedge clk);
      readNow(12'h010, d);
      checkOutput("bypass_ffff", d, 32'h0000_FFFF);
      pins = 16'h5555;
      repeat (3) @(negedge clk);
      readNow(12'h010, d);
      checkOutput("bypass_5555", d, 32'h0000_5555);
      pins = 16'hAAAA;
      repeat (3) @(negedge clk);
      readNow(12'h010, d);
      checkOutput("bypass_aaaa", d, 32'h0000_AAAA);

      pins = '0;
      repeat (5) @(negedge clk);
      applyStimulus(12'h004, 2, 32'd4);
      applyStimulus(12'h000, 2, 32'd3);

      // Two-tick pulse must be filtered out completely
      seen = 1'b0;
      pins = 16'h0001;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 9) pins = '0;
         readNow(12'h010, d);
         if (d[0]) seen = 1'b1;
      end
      checkOutput("filter_glitch_2tick", 32'(seen), 32'h0);

      // Three-tick pulse reaches IN on its third tick
      rose_at = -1;
      pins = 16'h0001;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         if (i == 14) pins = '0;
         readNow(12'h010, d);
         if (d[0] && rose_at < 0) rose_at = i;
      end
      checkOutput("filter_3tick_rise", 32'(rose_at >= 12 && rose_at <= 16), 32'h1);
      repeat (40) @(negedge clk);
      readNow(12'h010, d);
      checkOutput("filter_return_low", d, 32'h0);

      applyStimulus(12'h000, 2, 32'h0);
      applyStimulus(12'h004, 2, 32'h0);
      pins = 16'h0002;
      repeat (5) @(negedge clk);
      applyStimulus(12'h030, 2, 32'h1);
      applyStimulus(12'h034, 2, 32'h2);
      readNow(12'h03C, d);
      checkOutput("stat_before_edges", d, 32'h0);

      pins = 16'h0003;
      repeat (3) @(negedge clk);
      readNow(12'h03C, d);
      checkOutput("stat_same_clk_as_in", d, 32'h0);
      @(negedge clk);
      readNow(12'h03C, d);
      checkOutput("stat_rise0", d, 32'h1);
      checkOutput("irq_lags_flag", 32'(irq), 32'h0);
      @(negedge clk);
      checkOutput("irq_asserted", 32'(irq), 32'h1);

      pins = 16'h0001;
      repeat (5) @(negedge clk);
      readNow(12'h03C, d);
      checkOutput("stat_fall1", d, 32'h3);
      pins = 16'h0000;
      repeat (5) @(negedge clk);
      readNow(12'h03C, d);
      checkOutput("stat_unenabled_fall0", d, 32'h3);

      // W1C of bit0 lands on the same clock as a new pin0 rise flag
      pins = 16'h0001;
      repeat (3) @(negedge clk);
      applyStimulus(12'h03C, 2, 32'h1);
      readNow(12'h03C, d);
      checkOutput("stat_set_beats_w1c", d, 32'h3);

      applyStimulus(12'h03C, 2, 32'h3);
      readNow(12'h03C, d);
      checkOutput("stat_w1c_all", d, 32'h0);
      @(negedge clk);
      checkOutput("irq_deassert", 32'(irq), 32'h0);

      // Reset while a rise is still in the synchroniser
      pins = 16'h0000;
      repeat (5) @(negedge clk);
      pins = 16'h0001;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_irq", 32'(irq), 32'h0);
      checkOutput("midreset_pin_out", 32'(pin_out), 32'h0);
      readNow(12'h03C, d);
      checkOutput("midreset_stat", d, 32'h0);
      readNow(12'h020, d);
      checkOutput("midreset_out", d, 32'h0);
      readNow(12'h030, d);
      checkOutput("midreset_rise_en", d, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      readNow(12'h010, d);
      checkOutput("postreset_in", d, 32'h1);
      readNow(12'h03C, d);
      checkOutput("postreset_stat", d, 32'h0);
      checkOutput("postreset_irq", 32'(irq), 32'h0);

      sel = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
